interp_out_packer: RTL

Output stage placed directly downstream of the bicubic `mul_add_2` weighted-sum pipeline. It aligns the upstream issue strobe with the pipeline's fixed 9-cycle latency and captures each 9-bit interpolated result. It saturates the result to an 8-bit pixel, tags it with start-of-frame and end-of-line markers from column/row counters, and buffers it in a FIFO drained by a ready/valid stream. It also drives a stall back to the issuing logic so that no in-flight result is lost under backpressure.

---
 rtl/interp_out_packer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/interp_out_packer.sv
`default_nettype none
// ============================================================================
//  Module   : interp_out_packer
//  Purpose  : Realigns the mul_add_2 issue strobe with its result, saturates to
//             8 bits, tags SOF/EOL and streams pixels out through a FWFT FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module interp_out_packer #(
    parameter int LATENCY = 9,
    parameter int OUT_W   = 640,
    parameter int OUT_H   = 480,
    parameter int DEPTH   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [8:0] result,
    output logic       stall,
    output logic [7:0] m_data,
    output logic       m_sof,
    output logic       m_eol,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_done,
    output logic       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_STALL_TH = CNT_W'(DEPTH - LATENCY - 2);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [LATENCY-1:0] vdly_q, vdly_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               stall_q, stall_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;

    logic [9:0]         mem_q [DEPTH];

    logic               aligned_valid;
    logic [7:0]         pix;
    logic               last_col;
    logic               last_row;
    logic               tag_sof;
    logic               tag_eol;
    logic [9:0]         wr_word;
    logic               fifo_full;
    logic               fifo_nonempty;
    logic               do_read;
    logic               do_write;
    logic               do_drop;
    logic [9:0]         head_word;

    assign aligned_valid = vdly_q[LATENCY-1];

    // Any value with bit 8 set exceeds 255 and clips to full scale.
    assign pix      = result[8] ? 8'hFF : result[7:0];

    assign last_col = (col_q == C_COL_LAST);
    assign last_row = (row_q == C_ROW_LAST);
    assign tag_sof  = (col_q == '0) && (row_q == '0);
    assign tag_eol  = last_col;
    assign wr_word  = {tag_sof, tag_eol, pix};

    assign fifo_full     = (count_q == C_DEPTH);
    assign fifo_nonempty = (count_q != '0);
    assign do_read       = fifo_nonempty && m_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_write      = aligned_valid && (!fifo_full || do_read);
    assign do_drop       = aligned_valid && fifo_full && !do_read;

    // Empty FIFO presents an all-zero head so the stream outputs rest at 0.
    assign head_word = fifo_nonempty ? mem_q[rd_ptr_q] : 10'd0;

    assign m_valid    = fifo_nonempty;
    assign m_sof      = head_word[9];
    assign m_eol      = head_word[8];
    assign m_data     = head_word[7:0];
    assign stall      = stall_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    always_comb begin
        vdly_d       = vdly_q << 1;
        vdly_d[0]    = in_valid;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        if (do_read) begin
            rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        if (do_write) begin
            wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case ({do_write, do_read})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        if (do_drop) begin
            overflow_d = 1'b1;
        end

        // Threshold leaves room for the stall register delay plus every
        // result still travelling through the upstream pipeline.
        stall_d = (count_d >= C_STALL_TH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vdly_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            stall_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            vdly_q       <= vdly_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            col_q        <= col_d;
            row_q        <= row_d;
            stall_q      <= stall_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

endmodule
`default_nettype wire
